// File: rtl/rmad_pipe.sv
// Three-stage register/ALU/memory datapath: EX (regfile read + ALU), MEM (data memory), WB.
// Full forwarding from MEM and WB; a load in MEM feeding the EX instruction costs one stall cycle.
module rmad_pipe #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDRESS_WIDTH  = 5,
  parameter int unsigned MEM_ADDR_WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [ADDRESS_WIDTH-1:0] A1,
  input  logic [ADDRESS_WIDTH-1:0] A2,
  input  logic [ADDRESS_WIDTH-1:0] A3,
  input  logic                     RegWrite,
  input  logic [DATA_WIDTH-1:0]    ImmExt,
  input  logic                     ALUSrc,
  input  logic                     MemWrite,
  input  logic                     ResultSrc,
  input  logic [2:0]               ALUControl,
  output logic                     stall,
  output logic                     Zero,
  output logic                     wb_valid,
  output logic [ADDRESS_WIDTH-1:0] wb_addr,
  output logic [DATA_WIDTH-1:0]    wb_data
);

  localparam int unsigned NumRegs  = 2 ** ADDRESS_WIDTH;
  localparam int unsigned MemDepth = 2 ** MEM_ADDR_WIDTH;
  localparam int unsigned ShiftW   = $clog2(DATA_WIDTH);

  // MEM stage
  logic                     mem_valid_q;
  logic                     mem_regwrite_q;
  logic                     mem_resultsrc_q;
  logic                     mem_memwrite_q;
  logic [ADDRESS_WIDTH-1:0] mem_a3_q;
  logic [DATA_WIDTH-1:0]    mem_alu_q;
  logic [DATA_WIDTH-1:0]    mem_wdata_q;
  logic [MEM_ADDR_WIDTH-1:0] mem_idx;

  // WB stage
  logic                     wb_valid_q;
  logic                     wb_regwrite_q;
  logic [ADDRESS_WIDTH-1:0] wb_addr_q;
  logic [DATA_WIDTH-1:0]    wb_data_q;

  logic [DATA_WIDTH-1:0] rf_q [NumRegs];
  logic [DATA_WIDTH-1:0] dmem [MemDepth];

  logic [DATA_WIDTH-1:0] rd1, rd2, src_b, alu_result;
  logic [ShiftW-1:0]     shamt;
  logic                  accept;

  // Operand select: MEM result is newer than WB, which is newer than the regfile.
  // A load sitting in MEM is never forwarded from here; the stall covers it.
  always_comb begin
    rd1 = '0;
    if (A1 == '0) begin
      rd1 = '0;
    end else if (mem_valid_q && mem_regwrite_q && !mem_resultsrc_q && mem_a3_q == A1) begin
      rd1 = mem_alu_q;
    end else if (wb_valid_q && wb_regwrite_q && wb_addr_q == A1) begin
      rd1 = wb_data_q;
    end else begin
      rd1 = rf_q[A1];
    end
  end

  always_comb begin
    rd2 = '0;
    if (A2 == '0) begin
      rd2 = '0;
    end else if (mem_valid_q && mem_regwrite_q && !mem_resultsrc_q && mem_a3_q == A2) begin
      rd2 = mem_alu_q;
    end else if (wb_valid_q && wb_regwrite_q && wb_addr_q == A2) begin
      rd2 = wb_data_q;
    end else begin
      rd2 = rf_q[A2];
    end
  end

  assign src_b = ALUSrc ? ImmExt : rd2;
  assign shamt = src_b[ShiftW-1:0];

  always_comb begin
    alu_result = '0;
    unique case (ALUControl)
      3'b000: alu_result = rd1 + src_b;
      3'b001: alu_result = rd1 - src_b;
      3'b010: alu_result = rd1 & src_b;
      3'b011: alu_result = rd1 | src_b;
      3'b100: alu_result = rd1 ^ src_b;
      3'b101: alu_result = {{(DATA_WIDTH-1){1'b0}}, ($signed(rd1) < $signed(src_b))};
      3'b110: alu_result = rd1 << shamt;
      3'b111: alu_result = rd1 >> shamt;
      default: alu_result = '0;
    endcase
  end

  assign Zero = (alu_result == '0);

  // Stall on any source match against a load in MEM, whether or not the source is used.
  assign stall = in_valid && mem_valid_q && mem_resultsrc_q && mem_regwrite_q &&
                 (mem_a3_q != '0) && ((A1 == mem_a3_q) || (A2 == mem_a3_q));
  assign accept = in_valid && !stall;

  assign mem_idx = mem_alu_q[MEM_ADDR_WIDTH+1:2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_valid_q     <= 1'b0;
      mem_regwrite_q  <= 1'b0;
      mem_resultsrc_q <= 1'b0;
      mem_memwrite_q  <= 1'b0;
      mem_a3_q        <= '0;
      mem_alu_q       <= '0;
      mem_wdata_q     <= '0;
    end else begin
      mem_valid_q <= accept;
      if (accept) begin
        mem_regwrite_q  <= RegWrite;
        mem_resultsrc_q <= ResultSrc;
        mem_memwrite_q  <= MemWrite;
        mem_a3_q        <= A3;
        mem_alu_q       <= alu_result;
        mem_wdata_q     <= rd2;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid_q    <= 1'b0;
      wb_regwrite_q <= 1'b0;
      wb_addr_q     <= '0;
      wb_data_q     <= '0;
    end else begin
      wb_valid_q <= mem_valid_q;
      if (mem_valid_q) begin
        wb_regwrite_q <= mem_regwrite_q;
        wb_addr_q     <= mem_a3_q;
        wb_data_q     <= mem_resultsrc_q ? dmem[mem_idx] : mem_alu_q;
      end
    end
  end

  // Not reset; reset clears mem_valid_q asynchronously, so no store lands after rst rises.
  always_ff @(posedge clk) begin
    if (mem_valid_q && mem_memwrite_q) begin
      dmem[mem_idx] <= mem_wdata_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NumRegs; i++) begin
        rf_q[i] <= '0;
      end
    end else if (wb_valid_q && wb_regwrite_q && wb_addr_q != '0) begin
      rf_q[wb_addr_q] <= wb_data_q;
    end
  end

  assign wb_valid = wb_valid_q;
  assign wb_addr  = wb_addr_q;
  assign wb_data  = wb_data_q;

endmodule

// File: tb/tb_rmad_pipe.sv
// Bench for rmad_pipe: directed scenarios plus random instruction stream checked against an
// in-order architectural model (register array, word memory, queue of expected writebacks).
module tb_rmad_pipe;

  localparam int MAW = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [4:0]  A1, A2, A3;
  logic        RegWrite;
  logic [31:0] ImmExt;
  logic        ALUSrc, MemWrite, ResultSrc;
  logic [2:0]  ALUControl;
  logic        stall, Zero, wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  rmad_pipe #(.DATA_WIDTH(32), .ADDRESS_WIDTH(5), .MEM_ADDR_WIDTH(MAW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .A1(A1), .A2(A2), .A3(A3),
    .RegWrite(RegWrite), .ImmExt(ImmExt), .ALUSrc(ALUSrc), .MemWrite(MemWrite),
    .ResultSrc(ResultSrc), .ALUControl(ALUControl), .stall(stall), .Zero(Zero),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  int          compared = 0;
  int          mismatched = 0;
  int          cycle = 0;
  int          stalls_seen;
  logic [31:0] regs [32];
  logic [31:0] mem_m [int];
  exp_t        q [$];
  int          prev_acc_cycle = -10;
  logic        prev_load = 1'b0;
  logic [4:0]  prev_rd = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cycle);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd6: return a << b[4:0];
      default: return a >> b[4:0];
    endcase
  endfunction

  task automatic check_wb();
    if (q.size() > 0 && q[0].due == cycle) begin
      check("wb_valid", {31'b0, wb_valid}, 32'd1);
      check("wb_addr", {27'b0, wb_addr}, {27'b0, q[0].addr});
      check("wb_data", wb_data, q[0].data);
      void'(q.pop_front());
    end else begin
      check("wb_idle", {31'b0, wb_valid}, 32'd0);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) regs[i] = '0;
    q.delete();
    prev_acc_cycle = -10;
  endtask

  // Drives one instruction and holds it until accepted (at most one stall cycle expected).
  task automatic issue(input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] a3,
                       input logic rw, input logic [31:0] imm, input logic alusrc,
                       input logic mw, input logic rs, input logic [2:0] op);
    logic        exp_stall;
    logic [31:0] sa, sb, res, result;
    int          idx;
    in_valid = 1'b1; A1 = a1; A2 = a2; A3 = a3; RegWrite = rw; ImmExt = imm;
    ALUSrc = alusrc; MemWrite = mw; ResultSrc = rs; ALUControl = op;
    stalls_seen = 0;
    for (int k = 0; k < 2; k++) begin
      exp_stall = (prev_acc_cycle == cycle - 1) && prev_load && (prev_rd != 0) &&
                  ((a1 == prev_rd) || (a2 == prev_rd));
      @(negedge clk);
      if (stall) stalls_seen++;
      check("stall", {31'b0, stall}, {31'b0, exp_stall});
      check_wb();
      if (!exp_stall) begin
        sa  = regs[a1];
        sb  = alusrc ? imm : regs[a2];
        res = ref_alu(op, sa, sb);
        check("zero", {31'b0, Zero}, (res == 0) ? 32'd1 : 32'd0);
        idx = int'(res[MAW+1:2]);
        if (mw) mem_m[idx] = regs[a2];
        result = res;
        if (rs) result = mem_m.exists(idx) ? mem_m[idx] : 32'd0;
        if (rw && a3 != 0) regs[a3] = result;
        q.push_back('{due: cycle + 2, addr: a3, data: result});
        prev_acc_cycle = cycle;
        prev_load = rs && rw;
        prev_rd = a3;
      end
      @(posedge clk); #1;
      cycle++;
      if (!exp_stall) break;
    end
  endtask

  task automatic idle(input logic [4:0] a1);
    in_valid = 1'b0; A1 = a1; A2 = 5'($urandom()); A3 = 5'($urandom());
    RegWrite = 1'b1; ResultSrc = 1'b1; MemWrite = 1'($urandom());
    ALUControl = 3'($urandom()); ImmExt = $urandom();
    @(negedge clk);
    check("idle_stall", {31'b0, stall}, 32'd0);
    check_wb();
    @(posedge clk); #1;
    cycle++;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
    check("rst_wb_addr", {27'b0, wb_addr}, 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    cycle++;
    model_reset();
  endtask

  initial begin
    int w, kind;
    rst = 1'b1; in_valid = 1'b0; A1 = '0; A2 = '0; A3 = '0; RegWrite = 1'b0;
    ImmExt = '0; ALUSrc = 1'b0; MemWrite = 1'b0; ResultSrc = 1'b0; ALUControl = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_wb_valid", {31'b0, wb_valid}, 32'd0);
    check("reset_wb_addr", {27'b0, wb_addr}, 32'd0);
    check("reset_wb_data", wb_data, 32'd0);
    rst = 1'b0;

    // T1: reset with two instructions in flight, then every register reads back zero
    issue(0, 0, 1, 1, 32'd3, 1, 0, 0, 3'd0);
    issue(0, 0, 2, 1, 32'd4, 1, 0, 0, 3'd0);
    do_reset();
    for (int i = 1; i < 32; i++) issue(5'(i), 0, 5'(i), 1, 32'd0, 0, 0, 0, 3'd0);

    // T2: back-to-back forwarding
    issue(0, 0, 1, 1, 32'd5, 1, 0, 0, 3'd0);
    issue(1, 1, 2, 1, 32'd0, 0, 0, 0, 3'd0);
    check("t2_no_stall", stalls_seen, 0);

    // T3: store, load, dependent add
    issue(0, 1, 0, 0, 32'd8, 1, 1, 0, 3'd0);
    issue(0, 0, 3, 1, 32'd8, 1, 0, 1, 3'd0);
    issue(3, 1, 4, 1, 32'd0, 0, 0, 0, 3'd0);
    check("t3_stalls", stalls_seen, 1);

    // T4: writes to x0 are not forwarded
    issue(0, 0, 0, 1, 32'd7, 1, 0, 0, 3'd0);
    issue(0, 0, 5, 1, 32'd0, 1, 0, 0, 3'd0);

    // T5: slt, sub to zero, srl by 31
    issue(0, 0, 6, 1, 32'hFFFF_FFFF, 1, 0, 0, 3'd0);
    issue(0, 0, 7, 1, 32'd1, 1, 0, 0, 3'd0);
    issue(6, 7, 8, 1, 32'd0, 0, 0, 0, 3'd5);
    issue(7, 7, 9, 1, 32'd0, 0, 0, 0, 3'd1);
    issue(0, 0, 10, 1, 32'h8000_0000, 1, 0, 0, 3'd0);
    issue(10, 0, 11, 1, 32'd31, 1, 0, 0, 3'd7);

    // T6: idle cycle behind a load with matching A1, then consume via WB forwarding
    issue(0, 0, 12, 1, 32'd8, 1, 0, 1, 3'd0);
    idle(12);
    issue(12, 0, 13, 1, 32'd0, 0, 0, 0, 3'd0);
    check("t6_no_stall", stalls_seen, 0);

    // Random stream: initialise 16 words, then mixed ALU / load / store / idle
    for (int i = 0; i < 16; i++) issue(0, 5'($urandom_range(0, 7)), 0, 0, 32'(i * 4), 1, 1, 0, 3'd0);
    for (int n = 0; n < 400; n++) begin
      kind = $urandom_range(0, 99);
      w = $urandom_range(0, 15);
      if (kind < 55) begin
        issue(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              ($urandom_range(0, 9) != 0), ($urandom_range(0, 1) != 0) ? $urandom() :
              32'($urandom_range(0, 40)), 1'($urandom()), 0, 0, 3'($urandom()));
      end else if (kind < 80) begin
        issue(0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 1, 32'(w * 4), 1, 0, 1,
              3'd0);
      end else if (kind < 93) begin
        issue(0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 0, 32'(w * 4), 1, 1, 0,
              3'd0);
      end else begin
        idle(5'($urandom_range(0, 7)));
      end
    end
    repeat (3) idle(0);
    check("drain", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
